// File: rtl/clock_set_controller.sv
// Three-button time-set sequencer: walks hour/minute/second edit fields and commits them to the time counter.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat stepping on btn_inc/btn_dec.
module clock_set_controller #(
    parameter int unsigned BLINK_HALF     = 12_500_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter int unsigned REPEAT_DELAY   = 25_000_000,
    parameter int unsigned REPEAT_PERIOD  = 5_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [5:0] hour_now,
    input  logic [5:0] minute_now,
    input  logic [5:0] second_now,
    output logic       config_en,
    output logic [5:0] hour_config,
    output logic [5:0] minute_config,
    output logic [5:0] second_config,
    output logic       editing,
    output logic [1:0] field_sel,
    output logic       blink
);

    // state     | meaning
    // ST_RUN    | clock running, no edit in progress
    // ST_SET_H  | editing hour field
    // ST_SET_M  | editing minute field
    // ST_SET_S  | editing second field
    // ST_COMMIT | one-cycle config_en pulse, then back to ST_RUN
    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_H,
        ST_SET_M,
        ST_SET_S,
        ST_COMMIT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  mode_sr;
    logic [1:0]  inc_sr;
    logic [1:0]  dec_sr;
    logic        mode_ev;
    logic        inc_ev;
    logic        dec_ev;
    logic        step_inc;
    logic        step_dec;
    logic        any_ev;
    logic        in_edit;
    logic        nxt_edit;
    logic        entering;
    logic        timeout_hit;
    logic [1:0]  field_nxt;
    logic [31:0] timeout_cnt;
    logic [31:0] blink_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_sr <= 2'b00;
            inc_sr  <= 2'b00;
            dec_sr  <= 2'b00;
        end else begin
            mode_sr <= {mode_sr[0], btn_mode};
            inc_sr  <= {inc_sr[0], btn_inc};
            dec_sr  <= {dec_sr[0], btn_dec};
        end
    end

    assign mode_ev = mode_sr[0] & ~mode_sr[1];
    assign inc_ev  = inc_sr[0] & ~inc_sr[1];
    assign dec_ev  = dec_sr[0] & ~dec_sr[1];
    assign in_edit = (state == ST_SET_H) || (state == ST_SET_M) || (state == ST_SET_S);

`ifdef AUTO_REPEAT_EN
    logic [31:0] rpt_cnt;
    logic        rpt_armed;
    logic        held_one;
    logic        rpt_fire;

    assign held_one = inc_sr[0] ^ dec_sr[0];
    assign rpt_fire = in_edit && held_one && !(mode_ev || inc_ev || dec_ev) &&
                      (rpt_cnt == (rpt_armed ? REPEAT_PERIOD - 1 : REPEAT_DELAY - 1));

    // First repeat waits REPEAT_DELAY after the press edge, later ones REPEAT_PERIOD apart.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cnt   <= 32'd0;
            rpt_armed <= 1'b0;
        end else if (!in_edit || !held_one || mode_ev || inc_ev || dec_ev) begin
            rpt_cnt   <= 32'd0;
            rpt_armed <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt   <= 32'd0;
            rpt_armed <= 1'b1;
        end else begin
            rpt_cnt   <= rpt_cnt + 32'd1;
        end
    end

    assign step_inc = inc_ev | (rpt_fire & inc_sr[0]);
    assign step_dec = dec_ev | (rpt_fire & dec_sr[0]);
`else
    logic unused_rpt;
    assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign step_inc   = inc_ev;
    assign step_dec   = dec_ev;
`endif

    assign any_ev      = mode_ev | step_inc | step_dec;
    assign timeout_hit = (timeout_cnt == TIMEOUT_CYCLES - 1) && !any_ev;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (mode_ev) state_nxt = ST_SET_H;
            ST_SET_H:  if (mode_ev) state_nxt = ST_SET_M; else if (timeout_hit) state_nxt = ST_RUN;
            ST_SET_M:  if (mode_ev) state_nxt = ST_SET_S; else if (timeout_hit) state_nxt = ST_RUN;
            ST_SET_S:  if (mode_ev) state_nxt = ST_COMMIT; else if (timeout_hit) state_nxt = ST_RUN;
            ST_COMMIT: state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        field_nxt = 2'd0;
        case (state_nxt)
            ST_SET_H: field_nxt = 2'd1;
            ST_SET_M: field_nxt = 2'd2;
            ST_SET_S: field_nxt = 2'd3;
            default:  field_nxt = 2'd0;
        endcase
    end

    assign nxt_edit = (field_nxt != 2'd0);
    assign entering = nxt_edit && (state_nxt != state);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            editing   <= 1'b0;
            field_sel <= 2'd0;
            config_en <= 1'b0;
        end else begin
            state     <= state_nxt;
            editing   <= nxt_edit;
            field_sel <= field_nxt;
            config_en <= (state_nxt == ST_COMMIT);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timeout_cnt <= 32'd0;
        end else if (!nxt_edit || entering || any_ev) begin
            timeout_cnt <= 32'd0;
        end else begin
            timeout_cnt <= timeout_cnt + 32'd1;
        end
    end

    // Restarting on a step keeps the freshly changed digit visible.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= 32'd0;
            blink     <= 1'b0;
        end else if (!nxt_edit || entering || step_inc || step_dec) begin
            blink_cnt <= 32'd0;
            blink     <= 1'b0;
        end else if (blink_cnt == BLINK_HALF - 1) begin
            blink_cnt <= 32'd0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hour_config   <= 6'd0;
            minute_config <= 6'd0;
            second_config <= 6'd0;
        end else if ((state == ST_RUN) && mode_ev) begin
            hour_config   <= hour_now;
            minute_config <= minute_now;
            second_config <= second_now;
        end else if (in_edit && !mode_ev && (step_inc ^ step_dec)) begin
            case (state)
                ST_SET_H: hour_config <= step_inc ?
                    ((hour_config == 6'd23) ? 6'd0 : hour_config + 6'd1) :
                    ((hour_config == 6'd0) ? 6'd23 : hour_config - 6'd1);
                ST_SET_M: minute_config <= step_inc ?
                    ((minute_config == 6'd59) ? 6'd0 : minute_config + 6'd1) :
                    ((minute_config == 6'd0) ? 6'd59 : minute_config - 6'd1);
                ST_SET_S: second_config <= step_inc ?
                    ((second_config == 6'd59) ? 6'd0 : second_config + 6'd1) :
                    ((second_config == 6'd0) ? 6'd59 : second_config - 6'd1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: directed steps plus randomized button traffic against a field-level model.
module tb_clock_set_controller;

    localparam int TO = 100;
    localparam int BH = 8;

    logic       clock;
    logic       reset_n;
    logic       btn_mode, btn_inc, btn_dec;
    logic [5:0] hour_now, minute_now, second_now;
    logic       config_en;
    logic [5:0] hour_config, minute_config, second_config;
    logic       editing;
    logic [1:0] field_sel;
    logic       blink;

    clock_set_controller #(
        .BLINK_HALF    (BH),
        .TIMEOUT_CYCLES(TO),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .btn_mode     (btn_mode),
        .btn_inc      (btn_inc),
        .btn_dec      (btn_dec),
        .hour_now     (hour_now),
        .minute_now   (minute_now),
        .second_now   (second_now),
        .config_en    (config_en),
        .hour_config  (hour_config),
        .minute_config(minute_config),
        .second_config(second_config),
        .editing      (editing),
        .field_sel    (field_sel),
        .blink        (blink)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // model: m_field 0=idle, 1..3 = field being edited
    int m_field = 0;
    int m_h = 0, m_m = 0, m_s = 0;
    int m_commits = 0;
    int m_ch = 0, m_cm = 0, m_cs = 0;

    int cfg_count = 0, cfg_h = 0, cfg_m = 0, cfg_s = 0;
    int run_len = 0, max_run = 0;

    always @(negedge clock) begin
        if (config_en === 1'b1) begin
            cfg_count <= cfg_count + 1;
            cfg_h     <= int'(hour_config);
            cfg_m     <= int'(minute_config);
            cfg_s     <= int'(second_config);
            run_len   <= run_len + 1;
            if (run_len + 1 > max_run) max_run <= run_len + 1;
        end else begin
            run_len <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("editing", 32'(editing), 32'(m_field != 0));
        chk("field_sel", 32'(field_sel), 32'(m_field));
        chk("config_en_idle", 32'(config_en), 32'd0);
        if (m_field != 0) begin
            chk("hour_config", 32'(hour_config), 32'(m_h));
            chk("minute_config", 32'(minute_config), 32'(m_m));
            chk("second_config", 32'(second_config), 32'(m_s));
        end
        chk("commit_count", 32'(cfg_count), 32'(m_commits));
        if (m_commits > 0) begin
            chk("commit_hour", 32'(cfg_h), 32'(m_ch));
            chk("commit_minute", 32'(cfg_m), 32'(m_cm));
            chk("commit_second", 32'(cfg_s), 32'(m_cs));
        end
    endtask

    task automatic model_mode();
        case (m_field)
            0: begin m_h = int'(hour_now); m_m = int'(minute_now); m_s = int'(second_now); m_field = 1; end
            1: m_field = 2;
            2: m_field = 3;
            default: begin m_commits++; m_ch = m_h; m_cm = m_m; m_cs = m_s; m_field = 0; end
        endcase
    endtask

    task automatic model_step(input int dir);
        case (m_field)
            1: m_h = (m_h + 24 + dir) % 24;
            2: m_m = (m_m + 60 + dir) % 60;
            3: m_s = (m_s + 60 + dir) % 60;
            default: ;
        endcase
    endtask

    task automatic press(input logic m, input logic i, input logic d);
        @(negedge clock);
        btn_mode = m; btn_inc = i; btn_dec = d;
        @(negedge clock);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        repeat (5) @(negedge clock);
        if (m) model_mode();
        else if (i != d) model_step(i ? 1 : -1);
        check_model();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
        if (n > TO + 5) m_field = 0;
        check_model();
    endtask

    initial begin
        int found;
        int k;
        int r;
        int c0;
        reset_n = 1'b0;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        hour_now = 6'd0; minute_now = 6'd0; second_now = 6'd0;
        repeat (3) @(negedge clock);
        chk("rst_editing", 32'(editing), 32'd0);
        chk("rst_field_sel", 32'(field_sel), 32'd0);
        chk("rst_config_en", 32'(config_en), 32'd0);
        chk("rst_blink", 32'(blink), 32'd0);
        chk("rst_hour", 32'(hour_config), 32'd0);
        chk("rst_minute", 32'(minute_config), 32'd0);
        chk("rst_second", 32'(second_config), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // load and hour wrap
        hour_now = 6'd14; minute_now = 6'd5; second_now = 6'd9;
        press(1, 0, 0);
        repeat (9) press(0, 1, 0);
        press(0, 1, 0);
        chk("hour_wrap_up", 32'(hour_config), 32'd0);
        press(0, 0, 1);
        chk("hour_wrap_down", 32'(hour_config), 32'd23);
        // minute wrap and simultaneous buttons
        press(1, 0, 0);
        repeat (5) press(0, 0, 1);
        press(0, 0, 1);
        chk("minute_wrap_down", 32'(minute_config), 32'd59);
        repeat (31) press(0, 1, 0);
        press(0, 1, 1);
        chk("inc_dec_same_cycle", 32'(minute_config), 32'd30);
        press(1, 1, 0);
        chk("mode_wins_field", 32'(field_sel), 32'd3);
        chk("mode_wins_minute", 32'(minute_config), 32'd30);
        press(1, 0, 0);

        // full sequence
        hour_now = 6'd14; minute_now = 6'd5; second_now = 6'd9;
        c0 = cfg_count;
        press(1, 0, 0); press(0, 1, 0); press(0, 1, 0);
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        chk("full_seq_pulses", 32'(cfg_count - c0), 32'd1);
        chk("full_seq_hour", 32'(cfg_h), 32'd16);

        // blink phases from entry, then an inc clears blink
        hour_now = 6'd3;
        @(negedge clock); btn_mode = 1'b1;
        @(negedge clock); btn_mode = 1'b0;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (!found) begin
                if (field_sel == 2'd1) found = 1; else @(negedge clock);
            end
        end
        chk("blink_entry_found", 32'(found), 32'd1);
        model_mode();
        for (int j = 0; j <= 12; j++) begin
            chk("blink_phase", 32'(blink), 32'((j / BH) % 2));
            if (j < 12) @(negedge clock);
        end
        btn_inc = 1'b1;
        @(negedge clock); btn_inc = 1'b0;
        @(negedge clock);
        chk("blink_inc_clear", 32'(blink), 32'd0);
        model_step(1);
        repeat (3) @(negedge clock);
        check_model();
        idle(TO + 30);

        // timeout from SET_S
        press(1, 0, 0); press(1, 0, 0);
        c0 = cfg_count;
        @(negedge clock); btn_mode = 1'b1;
        @(negedge clock); btn_mode = 1'b0;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (!found) begin
                if (field_sel == 2'd3) found = 1; else @(negedge clock);
            end
        end
        chk("timeout_entry_found", 32'(found), 32'd1);
        k = 0;
        while (editing === 1'b1 && k < 3 * TO) begin
            @(negedge clock);
            k++;
        end
        chk("timeout_cycles", 32'(k), 32'(TO));
        chk("timeout_no_commit", 32'(cfg_count - c0), 32'd0);
        m_field = 0;
        check_model();

`ifdef AUTO_REPEAT_EN
        minute_now = 6'd0;
        press(1, 0, 0); press(1, 0, 0);
        @(negedge clock); btn_inc = 1'b1;
        repeat (31) @(negedge clock);
        btn_inc = 1'b0;
        repeat (5) @(negedge clock);
        chk("auto_repeat_minute", 32'(minute_config), 32'd7);
        m_m = 7;
        check_model();
        idle(TO + 30);
`endif

        // reset asserted mid-edit
        press(1, 0, 0); press(1, 0, 0);
        c0 = cfg_count;
        #3 reset_n = 1'b0;
        #1;
        chk("midreset_editing", 32'(editing), 32'd0);
        chk("midreset_field_sel", 32'(field_sel), 32'd0);
        chk("midreset_hour", 32'(hour_config), 32'd0);
        @(negedge clock); reset_n = 1'b1;
        m_field = 0;
        repeat (2) @(negedge clock);
        chk("midreset_no_commit", 32'(cfg_count - c0), 32'd0);

        // randomized traffic
        for (int it = 0; it < 200; it++) begin
            hour_now   = 6'($urandom_range(0, 23));
            minute_now = 6'($urandom_range(0, 59));
            second_now = 6'($urandom_range(0, 59));
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: press(1, 0, 0);
                3, 4:    press(0, 1, 0);
                5, 6:    press(0, 0, 1);
                7:       press(0, 1, 1);
                8:       begin
                             if ($urandom_range(0, 1) == 1) press(1, 1, 0);
                             else press(1, 0, 1);
                         end
                default: idle(($urandom_range(0, 1) == 1) ? TO + 30 : 20);
            endcase
        end

        chk("config_pulse_width", 32'(max_run), 32'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
